// File: rtl/serial_seq_ctrl_if.sv
// ============================================================================
// Module : serial_seq_ctrl_if
// Brief  : Request and sequencing-control bundle for serial_seq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_seq_ctrl_if #(
  parameter int CNT_W = 4
) ();

  logic             sw1;
  logic             m0;
  logic             m1;
  logic             m2;
  logic             cin;
  logic             load;
  logic             shift_en;
  logic [2:0]       mode;
  logic             cin_q;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             done;

  modport master (
    output sw1, m0, m1, m2, cin,
    input  load, shift_en, mode, cin_q, bit_idx, busy, done
  );

  modport slave (
    input  sw1, m0, m1, m2, cin,
    output load, shift_en, mode, cin_q, bit_idx, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/serial_seq_ctrl.sv
// ============================================================================
// Module : serial_seq_ctrl
// Brief  : Turns a start press into one load / WIDTH-shift / done sequence.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sw1_q;
  logic             w_start;
  logic [2:0]       w_mode_in;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic             r_cin_q;
  logic             w_cin_nxt;
  logic [CNT_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] w_bit_idx_nxt;
  logic             r_load;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_done;

  assign w_mode_in = {bus.m2, bus.m1, bus.m0};
  assign w_start   = bus.sw1 & ~r_sw1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_cin_nxt     = r_cin_q;
    w_bit_idx_nxt = r_bit_idx;
    unique case (r_state)
      S_IDLE: begin
        // A start with mode 000 is a NOP and leaves every output untouched.
        if (w_start && (w_mode_in != 3'b000)) begin
          w_state_nxt   = S_LOAD;
          w_mode_nxt    = w_mode_in;
          w_cin_nxt     = bus.cin;
          w_bit_idx_nxt = '0;
        end
      end
      S_LOAD: begin
        w_state_nxt   = S_SHIFT;
        w_bit_idx_nxt = '0;
      end
      S_SHIFT: begin
        if (r_bit_idx == C_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_bit_idx_nxt = r_bit_idx + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  // sw1_q resets high so a button held through reset cannot start an operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw1_q    <= 1'b1;
      r_mode     <= 3'b000;
      r_cin_q    <= 1'b0;
      r_bit_idx  <= '0;
      r_load     <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sw1_q    <= bus.sw1;
      r_mode     <= w_mode_nxt;
      r_cin_q    <= w_cin_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_load     <= (w_state_nxt == S_LOAD);
      r_shift_en <= (w_state_nxt == S_SHIFT);
      r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.load     = r_load;
  assign bus.shift_en = r_shift_en;
  assign bus.mode     = r_mode;
  assign bus.cin_q    = r_cin_q;
  assign bus.bit_idx  = r_bit_idx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_seq_ctrl.sv
// ============================================================================
// Module : tb_serial_seq_ctrl
// Brief  : Self-checking bench for serial_seq_ctrl (WIDTH=8 and WIDTH=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_seq_ctrl;

  typedef struct packed {
    logic       load;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [3:0] bit_idx;
    logic [2:0] mode;
    logic       cin_q;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t q[$];
  obs_t exp_o;
  obs_t got_o;

  serial_seq_ctrl_if #(.CNT_W(4)) bus1 ();
  serial_seq_ctrl_if #(.CNT_W(2)) bus2 ();

  serial_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_seq_ctrl #(.WIDTH(2), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic obs_t rec(input logic l, input logic s, input logic b, input logic d,
                               input int idx, input logic [2:0] m, input logic c);
    return {l, s, b, d, 4'(idx), m, c};
  endfunction

  function automatic obs_t sample1();
    return {bus1.load, bus1.shift_en, bus1.busy, bus1.done, bus1.bit_idx, bus1.mode, bus1.cin_q};
  endfunction

  function automatic obs_t sample2();
    return {bus2.load, bus2.shift_en, bus2.busy, bus2.done, {2'b00, bus2.bit_idx}, bus2.mode, bus2.cin_q};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in1(input logic [2:0] m, input logic c);
    {bus1.m2, bus1.m1, bus1.m0} = m;
    bus1.cin = c;
  endtask

  // Expected per-cycle outputs for one accepted start, from the cycle after
  // the start edge through the first idle cycle.
  task automatic push_op(input logic [2:0] m, input logic c, input int w);
    q.push_back(rec(1'b1, 1'b0, 1'b1, 1'b0, 0, m, c));
    for (int i = 0; i < w; i++) q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, i, m, c));
    q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, w - 1, m, c));
    q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, w - 1, m, c));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.sw1 = 1'b0; set_in1(3'b000, 1'b0);
    bus2.sw1 = 1'b0; bus2.m0 = 1'b0; bus2.m1 = 1'b0; bus2.m2 = 1'b0; bus2.cin = 1'b0;
    step(); step();
    exp_o = rec(1'b0, 1'b0, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    got_o = sample1();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b expected %b", got_o, exp_o);
    end
    got_o = sample2();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL reset_dut2: got %b expected %b", got_o, exp_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_op();
    set_in1(3'b001, 1'b1);
    bus1.sw1 = 1'b1;
    push_op(3'b001, 1'b1, 8);
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL basic_op cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
      if (i == 1) bus1.sw1 = 1'b0;
    end
  endtask

  task automatic test_held_button();
    bus1.sw1 = 1'b0;
    step();
    set_in1(3'b011, 1'b0);
    bus1.sw1 = 1'b1;
    push_op(3'b011, 1'b0, 8);
    for (int i = 0; i < 19; i++) q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 7, 3'b011, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL held_button cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
    end
    bus1.sw1 = 1'b0;
  endtask

  task automatic test_ignore_midop();
    step();
    set_in1(3'b101, 1'b1);
    bus1.sw1 = 1'b1;
    push_op(3'b101, 1'b1, 8);
    for (int i = 0; i < 3; i++) q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 7, 3'b101, 1'b1));
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL ignore_midop cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
      if (i == 0) bus1.sw1 = 1'b0;
      if (i == 2) set_in1(3'b111, 1'b0);
      if (i == 4) bus1.sw1 = 1'b1;   // new press lands while bit_idx==3
    end
    bus1.sw1 = 1'b0;
  endtask

  task automatic test_nop_mode();
    set_in1(3'b000, 1'b0);
    step();
    bus1.sw1 = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 7, 3'b101, 1'b1));
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL nop_mode cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
    end
    bus1.sw1 = 1'b0;
    set_in1(3'b110, 1'b0);
    step();
    bus1.sw1 = 1'b1;
    push_op(3'b110, 1'b0, 8);
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL after_nop cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
      if (i == 0) bus1.sw1 = 1'b0;
    end
  endtask

  task automatic test_reset_midop();
    step();
    set_in1(3'b010, 1'b1);
    bus1.sw1 = 1'b1;
    push_op(3'b010, 1'b1, 8);
    for (int i = 0; i < 7; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL pre_abort cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
    end
    q.delete();
    rst = 1'b1;
    #1;
    exp_o = rec(1'b0, 1'b0, 1'b0, 1'b0, 0, 3'b000, 1'b0);
    got_o = sample1();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected %b", got_o, exp_o);
    end
    for (int i = 0; i < 2; i++) q.push_back(exp_o);
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL rst_hold cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 0, 3'b000, 1'b0));
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL no_restart cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
      if (i == 2) bus1.sw1 = 1'b0;
    end
    bus1.sw1 = 1'b1;
    push_op(3'b010, 1'b1, 8);
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample1();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL post_reset_op cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
    end
    bus1.sw1 = 1'b0;
  endtask

  task automatic test_width2();
    bus2.m0 = 1'b0; bus2.m1 = 1'b0; bus2.m2 = 1'b1; bus2.cin = 1'b1;
    bus2.sw1 = 1'b1;
    push_op(3'b100, 1'b1, 2);
    q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1, 3'b100, 1'b1));
    for (int i = 0; q.size() > 0; i++) begin
      step();
      exp_o = q.pop_front();
      got_o = sample2();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL width2 cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
      if (i == 0) bus2.sw1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_held_button();
    test_ignore_midop();
    test_nop_mode();
    test_reset_midop();
    test_width2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
